// File: rtl/pc_fetch_if.sv
// Instruction-bus bundle between the fetch unit and the instruction memory port.
interface pc_fetch_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;

  // Fetch unit side: issues address/request, receives data/ack.
  modport master (
    output ibus_req,
    output ibus_addr,
    input  ibus_ack,
    input  ibus_rdata
  );

  // Memory side.
  modport slave (
    input  ibus_req,
    input  ibus_addr,
    output ibus_ack,
    output ibus_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: sequential PC generation, prioritised redirects,
// one-entry skid buffer for stalls, and request discard after a redirect.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_ex,
  input  logic [31:0] branch_tar_addr_ex,
  input  logic        branch_flag_pred,
  input  logic [31:0] branch_tar_addr_pred,
  pc_fetch_if.master  ibus,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [15:0] redirect_cnt
);

  localparam logic        STOP      = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ibus_addr_reg, ibus_addr_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic [31:0] skid_inst_reg, skid_inst_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_inst_reg, if_inst_next;
  logic        if_valid_reg, if_valid_next;
  logic [15:0] redirect_cnt_reg, redirect_cnt_next;

  logic        out_stop;
  logic        pred_redir;
  logic        redirect;
  logic [31:0] redir_target;
  logic        delivered;

  // Only the IF/ID stall bit matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign out_stop     = (stall[1] == STOP);
  assign pred_redir   = branch_flag_pred & if_valid_reg & ~out_stop;
  assign redirect     = flush | branch_flag_ex | pred_redir;
  assign redir_target = flush          ? new_pc :
                        branch_flag_ex ? branch_tar_addr_ex :
                                         branch_tar_addr_pred;

  assign ibus.ibus_req  = (state_reg == REQ) || (state_reg == DISCARD);
  assign ibus.ibus_addr = ibus_addr_reg;
  assign if_pc          = if_pc_reg;
  assign if_inst        = if_inst_reg;
  assign if_valid       = if_valid_reg;
  assign redirect_cnt   = redirect_cnt_reg;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      pc_reg           <= RESET_PC;
      ibus_addr_reg    <= RESET_PC;
      skid_pc_reg      <= ZERO_WORD;
      skid_inst_reg    <= ZERO_WORD;
      if_pc_reg        <= ZERO_WORD;
      if_inst_reg      <= ZERO_WORD;
      if_valid_reg     <= 1'b0;
      redirect_cnt_reg <= 16'h0000;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      ibus_addr_reg    <= ibus_addr_next;
      skid_pc_reg      <= skid_pc_next;
      skid_inst_reg    <= skid_inst_next;
      if_pc_reg        <= if_pc_next;
      if_inst_reg      <= if_inst_next;
      if_valid_reg     <= if_valid_next;
      redirect_cnt_reg <= redirect_cnt_next;
    end
  end

  // Next-state, fetch address, skid and presented-instruction logic.
  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    ibus_addr_next    = ibus_addr_reg;
    skid_pc_next      = skid_pc_reg;
    skid_inst_next    = skid_inst_reg;
    if_pc_next        = if_pc_reg;
    if_inst_next      = if_inst_reg;
    if_valid_next     = if_valid_reg;
    redirect_cnt_next = redirect_cnt_reg;
    delivered         = 1'b0;

    case (state_reg)
      IDLE: begin
        // A stray ack here belongs to a request abandoned by reset.
        state_next     = REQ;
        ibus_addr_next = redirect ? redir_target : pc_reg;
      end
      REQ: begin
        if (redirect) begin
          if (ibus.ibus_ack) begin
            ibus_addr_next = redir_target;
          end else begin
            // Address must stay stable until the outstanding ack arrives.
            state_next = DISCARD;
          end
        end else if (ibus.ibus_ack) begin
          pc_next        = pc_reg + 32'd4;
          ibus_addr_next = pc_reg + 32'd4;
          if (!out_stop) begin
            if_pc_next    = ibus_addr_reg;
            if_inst_next  = ibus.ibus_rdata;
            if_valid_next = 1'b1;
            delivered     = 1'b1;
          end else begin
            skid_pc_next   = ibus_addr_reg;
            skid_inst_next = ibus.ibus_rdata;
            state_next     = HOLD;
          end
        end
      end
      DISCARD: begin
        if (ibus.ibus_ack) begin
          state_next     = REQ;
          ibus_addr_next = redirect ? redir_target : pc_reg;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next     = REQ;
          ibus_addr_next = redir_target;
        end else if (!out_stop) begin
          if_pc_next     = skid_pc_reg;
          if_inst_next   = skid_inst_reg;
          if_valid_next  = 1'b1;
          delivered      = 1'b1;
          state_next     = REQ;
          ibus_addr_next = pc_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (redirect) begin
      pc_next        = redir_target;
      if_valid_next  = 1'b0;
      if_inst_next   = ZERO_WORD;
      skid_pc_next   = ZERO_WORD;
      skid_inst_next = ZERO_WORD;
      if (redirect_cnt_reg != 16'hFFFF) begin
        redirect_cnt_next = redirect_cnt_reg + 16'd1;
      end
    end else if (!out_stop && !delivered) begin
      // Downstream advanced but nothing new arrived: present a bubble.
      if_valid_next = 1'b0;
      if_inst_next  = ZERO_WORD;
    end
  end

endmodule
